// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: accumulate-mode encodings,
// tracker FSM states and the default data width.
package hilo_pkg;

   localparam int HILO_DATA_W = 32;

   // mul_acc encodings; the fourth code is reserved and behaves as a plain write
   localparam logic [1:0] HILO_ACC_WR  = 2'b00;
   localparam logic [1:0] HILO_ACC_ADD = 2'b01;
   localparam logic [1:0] HILO_ACC_SUB = 2'b10;

   // IDLE: nothing in flight, BUSY: live products only, DRAIN: killed products still to emerge
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } hilo_state_e;

endpackage

// File: rtl/hilo_pend_tracker.sv
// Tracks multiplies in flight through MUL: live (pend) and killed-by-flush (drop)
// counts, the IDLE/BUSY/DRAIN state, issue back-pressure, and whether each
// arriving product is written or discarded. Products arrive in issue order, so
// all killed products emerge before any live one.
module hilo_pend_tracker
   import hilo_pkg::*;
#(
   parameter int MAX_PEND = 4,
   parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   input  logic flush,
   input  logic mul_issue,
   input  logic mul_done,
   output logic issue_ready,
   output logic pend_busy,
   output logic prod_write
);

   localparam logic [CNT_W:0] MAX_PEND_W = (CNT_W + 1)'(MAX_PEND);

   logic [CNT_W-1:0] pend_q, pend_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   hilo_state_e      state_q, state_d;

   logic accept;
   logic take_drop;
   logic take_pend;

   // Issue acceptance and routing of an arriving product (drop first, then live, else spurious)
   always_comb begin
      issue_ready = ({1'b0, pend_q} + {1'b0, drop_q}) < MAX_PEND_W;
      accept      = mul_issue && !stall && !flush && issue_ready;
      take_drop   = mul_done && (state_q == ST_DRAIN);
      take_pend   = mul_done && (state_q == ST_BUSY);
      prod_write  = take_pend;
      pend_busy   = (pend_q != '0);
   end

   // Next counter values and the state they imply
   always_comb begin
      pend_d  = pend_q;
      drop_d  = drop_q;
      state_d = state_q;
      if (flush) begin
         drop_d = drop_q + pend_q - CNT_W'(take_drop | take_pend);
         pend_d = '0;
      end else begin
         drop_d = drop_q - CNT_W'(take_drop);
         pend_d = pend_q + CNT_W'(accept) - CNT_W'(take_pend);
      end
      if (drop_d != '0) begin
         state_d = ST_DRAIN;
      end else if (pend_d != '0) begin
         state_d = ST_BUSY;
      end else begin
         state_d = ST_IDLE;
      end
   end

   // Counter and state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q  <= '0;
         drop_q  <= '0;
         state_q <= ST_IDLE;
      end else begin
         pend_q  <= pend_d;
         drop_q  <= drop_d;
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO pair fed by the EX-stage multiplier. Captures products,
// applies committed MTHI/MTLO writes and serves MFHI/MFLO reads with a stall
// while a product is still in flight.
// Build option: define HILO_ACC_EN to make written products accumulate into
// {HI,LO} (MADD/MSUB); otherwise every product overwrites HI/LO.
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int DATA_W   = HILO_DATA_W,
   parameter int MAX_PEND = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              mul_issue,
   input  logic              mul_done,
   input  logic [DATA_W-1:0] mul_hi,
   input  logic [DATA_W-1:0] mul_lo,
   input  logic [1:0]        mul_acc,
   input  logic              mt_we_hi,
   input  logic              mt_we_lo,
   input  logic [DATA_W-1:0] mt_data,
   input  logic              mf_req,
   input  logic              mf_sel,
   output logic [DATA_W-1:0] mf_data,
   output logic              mf_stall,
   output logic              issue_ready,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);

   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [2*DATA_W-1:0] hilo_new;
   logic                prod_write;
   logic                pend_busy;
   logic                mt_hi;
   logic                mt_lo;

   hilo_pend_tracker #(
      .MAX_PEND (MAX_PEND)
   ) u_tracker (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .mul_issue   (mul_issue),
      .mul_done    (mul_done),
      .issue_ready (issue_ready),
      .pend_busy   (pend_busy),
      .prod_write  (prod_write)
   );

`ifdef HILO_ACC_EN
   // Combine the product with the current pair according to the accumulate mode
   always_comb begin
      hilo_new = {mul_hi, mul_lo};
      case (mul_acc)
         HILO_ACC_ADD: hilo_new = {hi_q, lo_q} + {mul_hi, mul_lo};
         HILO_ACC_SUB: hilo_new = {hi_q, lo_q} - {mul_hi, mul_lo};
         default:      hilo_new = {mul_hi, mul_lo};
      endcase
   end
`else
   logic unused_acc;
   assign unused_acc = ^mul_acc;

   // Without accumulation every product simply overwrites the pair
   always_comb begin
      hilo_new = {mul_hi, mul_lo};
   end
`endif

   // Next HI/LO: product capture first, then committed MT writes override their own half
   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      mt_hi = mt_we_hi && !stall && !flush;
      mt_lo = mt_we_lo && !stall && !flush;
      if (prod_write) begin
         {hi_d, lo_d} = hilo_new;
      end
      if (mt_hi) begin
         hi_d = mt_data;
      end
      if (mt_lo) begin
         lo_d = mt_data;
      end
   end

   // Read port with same-cycle MT bypass, and the read stall while work is live
   always_comb begin
      if (mf_sel) begin
         mf_data = mt_hi ? mt_data : hi_q;
      end else begin
         mf_data = mt_lo ? mt_data : lo_q;
      end
      mf_stall = mf_req && pend_busy;
      hi_out   = hi_q;
      lo_out   = lo_q;
   end

   // HI/LO registers
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a HI/LO scoreboard: expected pairs are queued
// when a product/MT/reset is driven and compared one cycle later.
module tb_hilo_unit;
   import hilo_pkg::*;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        mul_issue;
   logic        mul_done;
   logic [31:0] mul_hi;
   logic [31:0] mul_lo;
   logic [1:0]  mul_acc;
   logic        mt_we_hi;
   logic        mt_we_lo;
   logic [31:0] mt_data;
   logic        mf_req;
   logic        mf_sel;
   logic [31:0] mf_data;
   logic        mf_stall;
   logic        issue_ready;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;
   logic [63:0] exp_q[$];

   hilo_unit #(
      .DATA_W   (32),
      .MAX_PEND (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .mul_issue   (mul_issue),
      .mul_done    (mul_done),
      .mul_hi      (mul_hi),
      .mul_lo      (mul_lo),
      .mul_acc     (mul_acc),
      .mt_we_hi    (mt_we_hi),
      .mt_we_lo    (mt_we_lo),
      .mt_data     (mt_data),
      .mf_req      (mf_req),
      .mf_sel      (mf_sel),
      .mf_data     (mf_data),
      .mf_stall    (mf_stall),
      .issue_ready (issue_ready),
      .hi_out      (hi_out),
      .lo_out      (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a product beat; when keep is set, fold it into the reference HI/LO
   task automatic applyStimulus(input logic done, input logic keep, input logic [31:0] phi,
                                input logic [31:0] plo, input logic [1:0] acc);
      mul_done = done;
      mul_hi   = phi;
      mul_lo   = plo;
      mul_acc  = acc;
      if (done && keep) begin
`ifdef HILO_ACC_EN
         case (acc)
            2'b01:   {m_hi, m_lo} = {m_hi, m_lo} + {phi, plo};
            2'b10:   {m_hi, m_lo} = {m_hi, m_lo} - {phi, plo};
            default: {m_hi, m_lo} = {phi, plo};
         endcase
`else
         {m_hi, m_lo} = {phi, plo};
`endif
      end
   endtask

   task automatic expectNow();
      exp_q.push_back({m_hi, m_lo});
   endtask

   // Advance one cycle; inputs change at negedge, scoreboard entries compared there
   task automatic tick();
      logic [63:0] e;
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("hilo_pair", {hi_out, lo_out}, e);
      end
   endtask

   task automatic checkState(input string tag, input hilo_state_e s);
      checkOutput(tag, 64'(dut.u_tracker.state_q), 64'(s));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; mul_issue = 1'b0; mul_done = 1'b0;
      mul_hi = '0; mul_lo = '0; mul_acc = 2'b00; mt_we_hi = 1'b0; mt_we_lo = 1'b0;
      mt_data = '0; mf_req = 1'b0; mf_sel = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checkOutput("rst_hi", 64'(hi_out), 64'd0);
      checkOutput("rst_lo", 64'(lo_out), 64'd0);
      checkOutput("rst_issue_ready", 64'(issue_ready), 64'd1);
      checkOutput("rst_mf_stall", 64'(mf_stall), 64'd0);
      checkOutput("rst_mf_data", 64'(mf_data), 64'd0);
      checkState("rst_state", ST_IDLE);

      // Single multiply, MFLO waits for it
      mul_issue = 1'b1;
      tick();
      mul_issue = 1'b0; mf_req = 1'b1; mf_sel = 1'b0;
      #1 checkOutput("t1_mf_stall_a", 64'(mf_stall), 64'd1);
      tick();
      #1 checkOutput("t1_mf_stall_b", 64'(mf_stall), 64'd1);
      tick();
      applyStimulus(1'b1, 1'b1, 32'd0, 32'd200, 2'b00);
      expectNow();
      #1 checkOutput("t1_mf_stall_c", 64'(mf_stall), 64'd1);
      tick();
      mul_done = 1'b0;
      #1;
      checkOutput("t1_mf_stall_d", 64'(mf_stall), 64'd0);
      checkOutput("t1_mf_data", 64'(mf_data), 64'd200);
      checkState("t1_state", ST_IDLE);
      mf_req = 1'b0;

      // Fill to MAX_PEND, over-issue ignored, drain
      for (int i = 0; i < 4; i++) begin
         mul_issue = 1'b1;
         #1 checkOutput("t2_ready_fill", 64'(issue_ready), 64'd1);
         tick();
      end
      #1 checkOutput("t2_ready_full", 64'(issue_ready), 64'd0);
      tick();
      mul_issue = 1'b0;
      #1;
      checkState("t2_state_busy", ST_BUSY);
      checkOutput("t2_pend", 64'(dut.u_tracker.pend_q), 64'd4);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(i), 32'(10 + i), 2'b00);
         expectNow();
         tick();
      end
      mul_done = 1'b0;
      #1;
      checkState("t2_state_idle", ST_IDLE);
      checkOutput("t2_ready_after", 64'(issue_ready), 64'd1);
      applyStimulus(1'b1, 1'b0, 32'h77, 32'h77, 2'b00);
      expectNow();
      tick();
      mul_done = 1'b0;

      // Flush with two in flight, one fresh issue, three products
      mul_issue = 1'b1;
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      mul_issue = 1'b0;
      #1;
      checkState("t3_state_drain", ST_DRAIN);
      checkOutput("t3_drop", 64'(dut.u_tracker.drop_q), 64'd2);
      checkOutput("t3_pend", 64'(dut.u_tracker.pend_q), 64'd0);
      mul_issue = 1'b1;
      tick();
      mul_issue = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'd0, 32'd1, 2'b00);
      expectNow();
      tick();
      #1 checkState("t3_state_drain2", ST_DRAIN);
      applyStimulus(1'b1, 1'b0, 32'd0, 32'd2, 2'b00);
      expectNow();
      tick();
      #1 checkState("t3_state_busy", ST_BUSY);
      applyStimulus(1'b1, 1'b1, 32'd0, 32'd3, 2'b00);
      expectNow();
      tick();
      mul_done = 1'b0;
      #1 checkState("t3_state_idle", ST_IDLE);

      // Product and MTLO in the same cycle, MFLO bypass
      mul_issue = 1'b1;
      tick();
      mul_issue = 1'b0;
      applyStimulus(1'b1, 1'b1, 32'hABC, 32'd5, 2'b00);
      mt_we_lo = 1'b1; mt_data = 32'd9; m_lo = 32'd9;
      mf_req = 1'b1; mf_sel = 1'b0;
      expectNow();
      #1 checkOutput("t4_mf_bypass", 64'(mf_data), 64'd9);
      tick();
      mul_done = 1'b0; mt_we_lo = 1'b0;

      // MTHI held off by stall, applied once stall drops
      stall = 1'b1; mt_we_hi = 1'b1; mt_data = 32'h55; mf_sel = 1'b1;
      expectNow();
      #1 checkOutput("t4_mf_stalled_mt", 64'(mf_data), 64'hABC);
      tick();
      stall = 1'b0;
      m_hi = 32'h55;
      expectNow();
      tick();
      mt_we_hi = 1'b0; mf_req = 1'b0;

      // Product capture proceeds under stall
      mul_issue = 1'b1;
      tick();
      mul_issue = 1'b0; stall = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'h66, 32'h67, 2'b00);
      expectNow();
      tick();
      mul_done = 1'b0; stall = 1'b0;

      // Accumulate modes (overwrite when the option is not built in)
      mt_we_hi = 1'b1; mt_data = 32'd0; m_hi = 32'd0;
      expectNow();
      tick();
      mt_we_hi = 1'b0; mt_we_lo = 1'b1; mt_data = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFF;
      expectNow();
      tick();
      mt_we_lo = 1'b0;
      mul_issue = 1'b1;
      tick();
      mul_issue = 1'b0;
      applyStimulus(1'b1, 1'b1, 32'd0, 32'd1, 2'b01);
      expectNow();
      tick();
      mul_done = 1'b0;
      mul_issue = 1'b1;
      tick();
      mul_issue = 1'b0;
      applyStimulus(1'b1, 1'b1, 32'd0, 32'd1, 2'b10);
      expectNow();
      tick();
      mul_done = 1'b0; mul_acc = 2'b00;

      // Reset with work in flight; the late product is spurious
      mul_issue = 1'b1;
      tick();
      tick();
      mul_issue = 1'b0;
      reset = 1'b1;
      m_hi = '0; m_lo = '0;
      expectNow();
      tick();
      reset = 1'b0;
      #1;
      checkOutput("t6_issue_ready", 64'(issue_ready), 64'd1);
      checkOutput("t6_pend", 64'(dut.u_tracker.pend_q), 64'd0);
      checkOutput("t6_drop", 64'(dut.u_tracker.drop_q), 64'd0);
      checkState("t6_state", ST_IDLE);
      applyStimulus(1'b1, 1'b0, 32'd0, 32'h99, 2'b00);
      expectNow();
      tick();
      mul_done = 1'b0;
      #1 checkState("t6_state_after", ST_IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
